// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and the MIPS SPECIAL funct values that decode into an operation.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Map a SPECIAL-opcode funct field onto the unit's op code; anything that
    // does not target HI/LO becomes a no-op.
    function automatic mdu_op_e funct_to_op(input logic [5:0] funct);
        mdu_op_e res;
        case (funct)
            FUNCT_MULT:  res = OP_MULT;
            FUNCT_MULTU: res = OP_MULTU;
            FUNCT_DIV:   res = OP_DIV;
            FUNCT_DIVU:  res = OP_DIVU;
            FUNCT_MTHI:  res = OP_MTHI;
            FUNCT_MTLO:  res = OP_MTLO;
            default:     res = OP_NOP7;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. One accumulator serves both the
// right-shifting shift-add multiplier and the left-shifting restoring divider:
// the low half starts as the multiplier/dividend, the high half collects the
// partial product/remainder. Magnitudes are processed; signs are fixed in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = 2 * WIDTH;

    mdu_state_e         state_r, state_next_s;
    mdu_op_e            op_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   acc_r, acc_step_s;
    logic [WIDTH-1:0]   mcand_r;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_r;      // dividend as supplied, for divide-by-zero
    logic               is_div_r;
    logic               dbz_r;
    logic               neg_lo_r;     // negate product / quotient
    logic               neg_hi_r;     // negate remainder (dividend sign)

    logic               accept_s, step_s, finish_s, mt_hi_s, mt_lo_s;
    logic               is_signed_s, is_div_op_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     sum_s;        // multiply partial sum with carry
    logic [WIDTH:0]     shifted_s;    // partial remainder after shift, one extra bit
    logic               borrow_s;
    logic [WIDTH-1:0]   diff_lo_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;
    logic [ACC_W-1:0]   prod_s;

    assign op_s = mdu_op_e'(op);

    // Operand classification and magnitude conversion at acceptance.
    always_comb begin
        is_signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
        is_div_op_s = (op_s == OP_DIV) || (op_s == OP_DIVU);
        if (is_signed_s && a[WIDTH-1]) begin
            a_mag_s = {WIDTH{1'b0}} - a;
        end else begin
            a_mag_s = a;
        end
        if (is_signed_s && b[WIDTH-1]) begin
            b_mag_s = {WIDTH{1'b0}} - b;
        end else begin
            b_mag_s = b;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        mt_hi_s      = 1'b0;
        mt_lo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op_s)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            accept_s     = 1'b1;
                            state_next_s = ST_RUN;
                        end
                        OP_MTHI: mt_hi_s = 1'b1;
                        OP_MTLO: mt_lo_s = 1'b1;
                        default: state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX: begin
                finish_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // One iteration of the shared datapath: shift-add or restoring subtract.
    // The stored remainder is always below the divisor, so it fits WIDTH bits;
    // only the shifted value needs the extra bit before the compare.
    always_comb begin
        sum_s      = {1'b0, acc_r[ACC_W-1:WIDTH]};
        shifted_s  = {acc_r[ACC_W-1:WIDTH], acc_r[WIDTH-1]};
        borrow_s   = (shifted_s < {1'b0, mcand_r});
        diff_lo_s  = shifted_s[WIDTH-1:0] - mcand_r;
        acc_step_s = acc_r;
        if (is_div_r) begin
            if (borrow_s) begin
                acc_step_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end else begin
                acc_step_s = {diff_lo_s, acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (acc_r[0]) begin
                sum_s = {1'b0, acc_r[ACC_W-1:WIDTH]} + {1'b0, mcand_r};
            end else begin
                sum_s = {1'b0, acc_r[ACC_W-1:WIDTH]};
            end
            acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and result mapping applied in FIX.
    always_comb begin
        if (neg_lo_r) begin
            prod_s = {ACC_W{1'b0}} - acc_r;
        end else begin
            prod_s = acc_r;
        end
        res_hi_s = prod_s[ACC_W-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
        if (is_div_r) begin
            if (dbz_r) begin
                res_lo_s = {WIDTH{1'b1}};
                res_hi_s = a_raw_r;
            end else begin
                if (neg_lo_r) begin
                    res_lo_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
                end else begin
                    res_lo_s = acc_r[WIDTH-1:0];
                end
                if (neg_hi_r) begin
                    res_hi_s = {WIDTH{1'b0}} - acc_r[ACC_W-1:WIDTH];
                end else begin
                    res_hi_s = acc_r[ACC_W-1:WIDTH];
                end
            end
        end else begin
            res_hi_s = prod_s[ACC_W-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Iteration counter: cleared on accept, stops at WIDTH-1 on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (step_s && (state_next_s == ST_RUN)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand latch at acceptance and accumulator update while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= {ACC_W{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            a_raw_r  <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            dbz_r    <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else if (accept_s) begin
            acc_r    <= {{WIDTH{1'b0}}, a_mag_s};
            mcand_r  <= b_mag_s;
            a_raw_r  <= a;
            is_div_r <= is_div_op_s;
            dbz_r    <= is_div_op_s && (b == {WIDTH{1'b0}});
            neg_lo_r <= is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_r <= is_signed_s && a[WIDTH-1];
        end else if (step_s) begin
            acc_r <= acc_step_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Registered outputs: HI/LO, busy, done and divide-by-zero pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy        <= (state_next_s != ST_IDLE);
            done        <= finish_s;
            div_by_zero <= finish_s && dbz_r;
            if (finish_s) begin
                hi <= res_hi_s;
                lo <= res_lo_s;
            end else if (mt_hi_s) begin
                hi <= a;
            end else if (mt_lo_s) begin
                lo <= a;
            end else begin
                hi <= hi;
                lo <= lo;
            end
        end
    end

endmodule
